barrel_rot_pipe: RTL and testbench

Registered, handshaked rotate stage around the left-rotate network. It accepts a word, a rotate amount and a direction, and normalises a right-rotate into the equivalent left amount. It runs the word through a log2(WIDTH)-level rotate-left mux network and delivers the result through a two-stage valid/ready pipeline. It sits between the datapath producer and any consumer that needs a rotated word without a combinational path through the rotator.

---
 rtl/barrel_rot_pipe.sv | 174 +++++++++++++++++
 tb/tb_barrel_rot_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_rot_pipe.sv
// -----------------------------------------------------------------------------
// barrel_rot_pipe
//   Registered, handshaked rotate stage.
//
//   Stage 1 captures a word plus its rotate amount. A right-rotate is turned
//   into the equivalent left amount here, at accept time. A log2(WIDTH)-level
//   rotate-left mux network then works on the stage-1 register. Stage 2
//   registers the rotated word, and stage 2 drives the outputs directly, so
//   there is no combinational path from the inputs to the output data.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous clear of both pipeline valids
//   in_valid   in   request present
//   in_ready   out  stage 1 can accept this cycle (combinational)
//   in_data    in   [WIDTH] word to rotate
//   in_amt     in   [SHW]   rotate amount 0..WIDTH-1
//   in_dir     in   0 = left, 1 = right
//   out_valid  out  result present (registered)
//   out_ready  in   consumer takes result this cycle
//   out_data   out  [WIDTH] rotated word (registered)
//   out_amt    out  [SHW]   effective left amount applied (registered)
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

module barrel_rot_pipe #(
    parameter int WIDTH = `WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt
);

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_data;
    logic [SHW-1:0]   r_s1_eff;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_s2_data;
    logic [SHW-1:0]   r_s2_eff;

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic [SHW-1:0]   w_eff;
    logic [WIDTH-1:0] w_lvl [0:SHW];

    // Right by n equals left by (WIDTH - n) mod WIDTH. That is the two's
    // complement of n in SHW bits, so right-by-0 maps to 0.
    assign w_eff = in_dir ? ({SHW{1'b0}} - in_amt) : in_amt;

    assign w_s2_free = !r_s2_v || out_ready;
    assign w_s1_adv  = r_s1_v && w_s2_free;
    assign in_ready  = !flush && (!r_s1_v || w_s2_free);
    assign w_in_fire = in_valid && in_ready;

    // Rotate network: level k rotates left by 2^k when bit k of the amount is set.
    assign w_lvl[0] = r_s1_data;
    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_lvl
            localparam int SH = 1 << k;
            assign w_lvl[k+1] = r_s1_eff[k]
                              ? {w_lvl[k][WIDTH-1-SH:0], w_lvl[k][WIDTH-1:WIDTH-SH]}
                              : w_lvl[k];
        end
    endgenerate

    // Stage 1: capture operands on input transfer, empty on flush or advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= {WIDTH{1'b0}};
            r_s1_eff  <= {SHW{1'b0}};
        end else if (w_in_fire) begin
            r_s1_v    <= 1'b1;
            r_s1_data <= in_data;
            r_s1_eff  <= w_eff;
        end else if (flush || w_s1_adv) begin
            r_s1_v    <= 1'b0;
        end else begin
            r_s1_v    <= r_s1_v;
        end
    end

    // Stage 2: take the rotated word when stage 1 advances; the valid bit
    // drops on drain or flush. Data is only written on advance, so it stays
    // stable through a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v    <= 1'b0;
            r_s2_data <= {WIDTH{1'b0}};
            r_s2_eff  <= {SHW{1'b0}};
        end else begin
            if (w_s1_adv) begin
                r_s2_data <= w_lvl[SHW];
                r_s2_eff  <= r_s1_eff;
            end else begin
                r_s2_data <= r_s2_data;
                r_s2_eff  <= r_s2_eff;
            end
            if (flush) begin
                r_s2_v <= 1'b0;
            end else if (w_s1_adv) begin
                r_s2_v <= 1'b1;
            end else if (out_ready) begin
                r_s2_v <= 1'b0;
            end else begin
                r_s2_v <= r_s2_v;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_data  = r_s2_data;
    assign out_amt   = r_s2_eff;

    barrel_rot_pipe_chk #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt)
    );

endmodule

// -----------------------------------------------------------------------------
// barrel_rot_pipe_chk
//   Protocol properties of the rotate pipe: a stalled output is stable and
//   stays valid, and no input is accepted in a flush cycle.
// -----------------------------------------------------------------------------
module barrel_rot_pipe_chk #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data,
    input logic [SHW-1:0]   out_amt
);

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_amt)));

    a_stall_held: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> out_valid);

    a_flush_blocks: assert property (@(posedge clk) disable iff (!rst_n)
        flush |-> !in_ready);

endmodule

// File: tb/tb_barrel_rot_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_rot_pipe
//   Directed scenarios for the rotate pipe at WIDTH = 8, followed by a
//   randomised queue-based scoreboard.
// -----------------------------------------------------------------------------
module tb_barrel_rot_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] a;
    } exp_t;

    barrel_rot_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit reference rotate: bit b moves to position (b + amt) mod 8.
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input int amt);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < 8; b++) r[(b + amt) % 8] = d[b];
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_amt = 3'd0; in_dir = 1'b0;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_checks++; if (out_amt !== 3'd0) begin n_errors++; $display("FAIL reset_out_amt got %0d want 0", out_amt); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] td [3] = '{8'h81, 8'h81, 8'hA5};
        logic [2:0] ta [3] = '{3'd1, 3'd1, 3'd0};
        logic       tr [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ed [3] = '{8'h03, 8'hC0, 8'hA5};
        logic [2:0] ea [3] = '{3'd1, 3'd7, 3'd0};
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1; in_data = td[i]; in_amt = ta[i]; in_dir = tr[i];
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early[%0d] out_valid got %b want 0", i, out_valid); end
            tick();
            #1;
            n_checks++; if (out_valid !== 1'b1 || out_data !== ed[i] || out_amt !== ea[i]) begin
                n_errors++; $display("FAIL basic_result[%0d] got v=%b d=%h a=%0d want v=1 d=%h a=%0d", i, out_valid, out_data, out_amt, ed[i], ea[i]);
            end
            tick();
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drained[%0d] out_valid got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_exhaustive(input logic dir);
        logic [7:0] ed;
        logic [2:0] ea;
        out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; in_data = 8'h01; in_amt = 3'(c); in_dir = dir;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) begin
                n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL exh_in_ready dir=%b c=%0d got %b want 1", dir, c, in_ready); end
            end
            tick();
            if (c >= 1) begin
                ea = dir ? 3'((8 - (c - 1)) % 8) : 3'(c - 1);
                ed = 8'h01 << ea;
                n_checks++; if (out_valid !== 1'b1 || out_data !== ed || out_amt !== ea) begin
                    n_errors++; $display("FAIL exh_result dir=%b amt=%0d got v=%b d=%h a=%0d want v=1 d=%h a=%0d", dir, c - 1, out_valid, out_data, out_amt, ed, ea);
                end
            end
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL exh_drained dir=%b out_valid got %b want 0", dir, out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] td [4] = '{8'h11, 8'h33, 8'h5A, 8'h80};
        logic [2:0] ta [4] = '{3'd1, 3'd2, 3'd3, 3'd7};
        logic       tr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] ed [4] = '{8'h22, 8'hCC, 8'hD2, 8'h01};
        logic [2:0] ea [4] = '{3'd1, 3'd6, 3'd3, 3'd1};
        int in_idx = 0;
        int out_idx = 0;
        int stall_left = 0;
        bit seen = 1'b0;
        bit released = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && !seen) begin seen = 1'b1; stall_left = 3; end
            out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            in_valid = (in_idx < 4);
            if (in_idx < 4) begin in_data = td[in_idx]; in_amt = ta[in_idx]; in_dir = tr[in_idx]; end
            #1;
            if (stall_left > 0) begin
                n_checks++; if (in_ready !== 1'b0 || in_idx != 2) begin
                    n_errors++; $display("FAIL bp_in_ready_stall got in_ready=%b accepted=%0d want 0 and 2", in_ready, in_idx);
                end
                n_checks++; if (out_valid !== 1'b1 || out_data !== ed[0] || out_amt !== ea[0]) begin
                    n_errors++; $display("FAIL bp_hold got v=%b d=%h a=%0d want v=1 d=%h a=%0d", out_valid, out_data, out_amt, ed[0], ea[0]);
                end
            end else if (released && out_idx < 4) begin
                n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_gap out_valid got %b want 1 at word %0d", out_valid, out_idx); end
            end
            if (out_valid && out_ready) begin
                released = 1'b1;
                n_checks++; if (out_idx >= 4 || out_data !== ed[out_idx % 4] || out_amt !== ea[out_idx % 4]) begin
                    n_errors++; $display("FAIL bp_order word=%0d got d=%h a=%0d want d=%h a=%0d", out_idx, out_data, out_amt, ed[out_idx % 4], ea[out_idx % 4]);
                end
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            tick();
            if (stall_left > 0) stall_left--;
        end
        in_valid = 1'b0;
        n_checks++; if (out_idx != 4) begin n_errors++; $display("FAIL bp_count got %0d want 4", out_idx); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h12; in_amt = 3'd1; in_dir = 1'b0;
        tick();
        in_data = 8'h34;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL flush_prefill out_valid got %b want 1", out_valid); end
        flush = 1'b1; in_data = 8'hEE;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_after got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd4; in_dir = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_new_early out_valid got %b want 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_amt !== 3'd4) begin
            n_errors++; $display("FAIL flush_new got v=%b d=%h a=%0d want v=1 d=f0 a=4", out_valid, out_data, out_amt);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_empty out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd1; in_dir = 1'b0;
        tick();
        in_data = 8'h3C; in_amt = 3'd0;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h4B) begin
            n_errors++; $display("FAIL arst_prefill got v=%b d=%h want v=1 d=4b", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_amt !== 3'd0) begin
            n_errors++; $display("FAIL arst_immediate got v=%b d=%h a=%0d want v=0 d=00 a=0", out_valid, out_data, out_amt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd2; in_dir = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL arst_stale out_valid got %b want 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h0F || out_amt !== 3'd6) begin
            n_errors++; $display("FAIL arst_first got v=%b d=%h a=%0d want v=1 d=0f a=6", out_valid, out_data, out_amt);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL arst_after out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t q [$];
        exp_t e;
        int   eff;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom_range(0, 7));
            in_dir    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            #1;
            if (flush) begin
                n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rnd_flush_ready cycle %0d got %b want 0", c, in_ready); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++; $display("FAIL rnd_spurious cycle %0d got d=%h a=%0d want no output", c, out_data, out_amt);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_amt !== e.a) begin
                        n_errors++; $display("FAIL rnd_data cycle %0d got d=%h a=%0d want d=%h a=%0d", c, out_data, out_amt, e.d, e.a);
                    end
                end
            end
            if (in_valid && in_ready) begin
                eff = in_dir ? (8 - int'(in_amt)) % 8 : int'(in_amt);
                e.d = rot_ref(in_data, eff);
                e.a = 3'(eff);
                q.push_back(e);
                n_checks++; if (q.size() > 2) begin n_errors++; $display("FAIL rnd_capacity cycle %0d got %0d in flight want <=2", c, q.size()); end
            end
            if (flush) q.delete();
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++; $display("FAIL rnd_drain_spurious got d=%h want no output", out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_amt !== e.a) begin
                        n_errors++; $display("FAIL rnd_drain got d=%h a=%0d want d=%h a=%0d", out_data, out_amt, e.d, e.a);
                    end
                end
            end
            tick();
        end
        n_checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL rnd_leftover got %0d pending out_valid=%b want 0 0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive(1'b0);
        test_exhaustive(1'b1);
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
